// File: rtl/bin2bcd_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the binary-to-BCD converter.
package bin2bcd_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] ERR_DIGIT = 4'hF;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

  // Bit counter must hold the value BIN_W itself, hence +1.
  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more, no carry out.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= DIGIT_W'(5)) ? d_i + DIGIT_W'(3) : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one shift per clock, results held.
// Define BIN2BCD_LZB_EN to build the leading-zero blanking mask; otherwise blank_mask is 0.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic                CLK100MHZ,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_bin,
  output logic                out_valid,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                overflow,
  output logic [DIGITS-1:0]   blank_mask
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = cnt_w(BIN_W);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   acc_q, acc_d, acc_adj;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vld_q, vld_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovo_q, ovo_d;
  logic [DIGITS-1:0]  blank_q, blank_d;
  logic [DIGITS-1:0]  blank_calc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (acc_q[g*DIGIT_W +: DIGIT_W]),
      .d_o (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BIN2BCD_LZB_EN
  // A digit is blankable when it and every digit above it are zero; digit 0 always shows.
  logic hi_zero;
  always_comb begin
    blank_calc = '0;
    hi_zero    = 1'b1;
    for (int i = DIGITS-1; i > 0; i--) begin
      hi_zero       = hi_zero && (acc_q[i*DIGIT_W +: DIGIT_W] == '0);
      blank_calc[i] = hi_zero;
    end
  end
`else
  assign blank_calc = '0;
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    bcd_d   = bcd_q;
    ovo_d   = ovo_q;
    blank_d = blank_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = in_bin;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The bit pushed out of the top digit means the value needs more digits.
        {acc_d, bin_d} = {acc_adj[BCD_W-2:0], bin_q, 1'b0};
        ovf_d          = ovf_q | acc_adj[BCD_W-1];
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        vld_d   = 1'b1;
        ovo_d   = ovf_q;
        bcd_d   = ovf_q ? {DIGITS{ERR_DIGIT}} : acc_q;
        blank_d = ovf_q ? '0 : blank_calc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      bcd_q   <= '0;
      ovo_q   <= 1'b0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      bcd_q   <= bcd_d;
      ovo_q   <= ovo_d;
      blank_q <= blank_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = vld_q;
  assign out_bcd    = bcd_q;
  assign overflow   = ovo_q;
  assign blank_mask = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: accepts are observed and expectations queued; a monitor checks each result.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    logic [7:0]  blank;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_bin;
  logic        out_valid;
  logic [31:0] out_bcd;
  logic        overflow;
  logic [7:0]  blank_mask;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ov_cnt = 0;
  int   last_acc = 0;
  int   acc_gap = 0;
  exp_t cur_exp;
  exp_t sb[$];

  bin2bcd_seq dut (
    .CLK100MHZ  (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bin     (in_bin),
    .out_valid  (out_valid),
    .out_bcd    (out_bcd),
    .overflow   (overflow),
    .blank_mask (blank_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Observe accepts (expected output exactly 28 edges after the accept edge) and check results.
  always @(negedge clk) begin
    exp_t e;
    if (rst) sb.delete();
    else begin
      if (in_valid && in_ready) begin
        e     = cur_exp;
        e.cyc = cyc + 29;
        sb.push_back(e);
        acc_gap  = cyc + 1 - last_acc;
        last_acc = cyc + 1;
      end
      if (out_valid) begin
        ov_cnt++;
        if (sb.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("latency_cycle", cyc, e.cyc);
          check("out_bcd", out_bcd, e.bcd);
          check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
          check("blank_mask", {24'd0, blank_mask}, {24'd0, e.blank});
        end
      end
    end
  end

  task automatic set_exp(input logic [31:0] b, input logic o, input logic [7:0] bl);
    cur_exp.bcd   = b;
    cur_exp.ovf   = o;
    cur_exp.blank = LZB ? bl : 8'h00;
    cur_exp.cyc   = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("result_timeout", sb.size(), 0);
  endtask

  task automatic send(input logic [26:0] v, input logic [31:0] b, input logic o, input logic [7:0] bl);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    set_exp(b, o, bl);
    in_valid = 1'b1;
    in_bin   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    int ov_save;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bin   = '0;
    set_exp(32'h0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_bcd", out_bcd, 32'h0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_blank", {24'd0, blank_mask}, 32'd0);
    @(posedge clk); #1;

    send(27'd0,         32'h00000000, 1'b0, 8'hFE);
    send(27'd9,         32'h00000009, 1'b0, 8'hFE);
    send(27'd10,        32'h00000010, 1'b0, 8'hFC);
    send(27'd305,       32'h00000305, 1'b0, 8'hF8);
    send(27'd99999999,  32'h99999999, 1'b0, 8'h00);
    send(27'd100000000, 32'hFFFFFFFF, 1'b1, 8'h00);
    send(27'd134217727, 32'hFFFFFFFF, 1'b1, 8'h00);

    // in_ready busy window after an accept
    set_exp(32'h12345678, 1'b0, 8'h00);
    in_valid = 1'b1;
    in_bin   = 27'd12345678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      if (!in_ready) n++;
    end while (!in_ready && n < 100);
    check("busy_cycles", n, 28);
    wait_idle();

    // in_valid held with changing data while busy: only A then B accepted, 29 apart
    set_exp(32'h00004321, 1'b0, 8'hF0);
    in_valid = 1'b1;
    in_bin   = 27'd4321;
    for (int j = 1; j <= 29; j++) begin
      @(posedge clk); #1;
      if (j < 29) in_bin = 27'(j * 1111 + 7);
      else begin
        set_exp(32'h00000777, 1'b0, 8'hF8);
        in_bin = 27'd777;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();
    check("accept_spacing", acc_gap, 29);

    // reset after 10 shifts aborts and clears the held result
    send(27'd99999999, 32'h99999999, 1'b0, 8'h00);
    set_exp(32'h12345678, 1'b0, 8'h00);
    in_valid = 1'b1;
    in_bin   = 27'd12345678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ov_save = ov_cnt;
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_bcd", out_bcd, 32'h0);
    check("abort_overflow", {31'd0, overflow}, 32'd0);
    repeat (40) @(negedge clk);
    check("abort_no_result", ov_cnt, ov_save);

    // in_valid coincident with rst is dropped
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_bin   = 27'd5;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    ov_save  = ov_cnt;
    @(negedge clk);
    check("rst_vs_valid_ready", {31'd0, in_ready}, 32'd1);
    repeat (35) @(negedge clk);
    check("rst_vs_valid_no_result", ov_cnt, ov_save);

    @(posedge clk); #1;
    send(27'd12345678, 32'h12345678, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
